// File: rtl/reset_requester.sv
// Reset request initiator: merges user, config-change and watchdog requests into
// fixed-width active-low reset pulses, then confirms downstream release with a timeout.
//
// state        | meaning
// S_IDLE       | waiting for a pending request; watchdog may run
// S_ASSERT     | rst_req_n driven low for PULSE_LEN cycles
// S_WAIT_READY | pulse released; waiting for ready to drop and return high
// S_HOLDOFF    | quiet period after done/timeout before the next pulse
module reset_requester #(
  parameter int PULSE_LEN     = 16,
  parameter int READY_TIMEOUT = 1024,
  parameter int HOLDOFF       = 64,
  parameter int WDT_LEN       = 1048576,
  parameter int CNT_W         = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       cfg_change,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  input  logic       ready_in,
  output logic       rst_req_n,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] cause
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_READY,
    S_HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] WDT_LAST     = CNT_W'(WDT_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pending_q, pending_d;
  logic [2:0]       cause_d;
  logic             timeout_d;
  logic             seen_low_q, seen_low_d;
  logic             ready_meta, ready_sync;
  logic [CNT_W-1:0] wdt_cnt;
  logic             wdt_fire;
  logic             wdt_run;
  logic [2:0]       req_acc;

  // ready_in comes from another reset domain; two-flop synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_meta <= 1'b0;
      ready_sync <= 1'b0;
    end else begin
      ready_meta <= ready_in;
      ready_sync <= ready_meta;
    end
  end

  assign wdt_run = wdt_en && (state_q == S_IDLE) && (pending_q == 3'b000);

  // wdt_fire is registered, so the request lands one cycle after the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt  <= '0;
      wdt_fire <= 1'b0;
    end else begin
      wdt_fire <= wdt_run && !wdt_kick && (wdt_cnt == WDT_LAST);
      if (!wdt_run || wdt_kick || (wdt_cnt == WDT_LAST)) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + CNT_ONE;
      end
    end
  end

  assign req_acc = pending_q | {wdt_fire, cfg_change, req};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ASSERT;
      cnt_q       <= '0;
      pending_q   <= 3'b000;
      cause       <= 3'b000;
      timeout_err <= 1'b0;
      seen_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      cause       <= cause_d;
      timeout_err <= timeout_d;
      seen_low_q  <= seen_low_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = req_acc;
    cause_d    = cause;
    timeout_d  = timeout_err;
    seen_low_d = seen_low_q;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Same-cycle requests are folded into cause via req_acc.
        if (req_acc != 3'b000) begin
          cause_d    = req_acc;
          pending_d  = 3'b000;
          cnt_d      = '0;
          timeout_d  = 1'b0;
          seen_low_d = 1'b0;
          state_d    = S_ASSERT;
        end
      end

      S_ASSERT: begin
        seen_low_d = seen_low_q | !ready_sync;
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_READY;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WAIT_READY: begin
        seen_low_d = seen_low_q | !ready_sync;
        // A ready that never dropped is stale and must not count as release.
        if (seen_low_q && ready_sync) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLDOFF;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_HOLDOFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rst_req_n = (state_q != S_ASSERT);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_reset_requester.sv
// Scoreboard bench for reset_requester: stimulus queues expected output events,
// a negedge monitor detects events on the DUT outputs and compares them in order.
module tb_reset_requester;

  localparam int K_PSTART = 0;
  localparam int K_PEND   = 1;
  localparam int K_DONE   = 2;
  localparam int K_TOUT   = 3;
  localparam int K_IDLE   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       cfg_change = 1'b0;
  logic       wdt_en = 1'b0;
  logic       wdt_kick = 1'b0;
  logic       ready_in = 1'b0;
  logic       rst_req_n;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [2:0] cause;

  reset_requester #(
    .PULSE_LEN    (16),
    .READY_TIMEOUT(1024),
    .HOLDOFF      (64),
    .WDT_LEN      (4096),
    .CNT_W        (21)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .cfg_change (cfg_change),
    .wdt_en     (wdt_en),
    .wdt_kick   (wdt_kick),
    .ready_in   (ready_in),
    .rst_req_n  (rst_req_n),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic string kname(int k);
    case (k)
      K_PSTART: return "pulse_start";
      K_PEND:   return "pulse_end";
      K_DONE:   return "done";
      K_TOUT:   return "timeout";
      K_IDLE:   return "idle_entry";
      default:  return "unknown";
    endcase
  endfunction

  task automatic push_ev(int kind, int c, int d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tick_to(int c);
    if (c > cyc) tick(c - cyc);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_val);
    end
  endtask

  task automatic observe(int kind, int data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got cyc=%0d data=%0h, required no event", kname(kind), cyc, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data != data) begin
        failures++;
        $display("FAIL event_%s: got %s cyc=%0d data=%0h, required %s cyc=%0d data=%0h",
                 kname(e.kind), kname(kind), cyc, data, kname(e.kind), e.cyc, e.data);
      end
    end
  endtask

  // Monitor
  logic prev_rst = 1'b1;
  logic prev_n = 1'b0;
  logic prev_busy = 1'b1;
  logic prev_to = 1'b0;
  int   plen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!rst_req_n && (prev_rst || prev_n)) begin
        observe(K_PSTART, int'({timeout_err, cause}));
        plen = 1;
      end else if (!rst_req_n) begin
        plen++;
      end
      if (rst_req_n && !prev_n) observe(K_PEND, plen);
      if (done) observe(K_DONE, 0);
      if (timeout_err && !prev_to) observe(K_TOUT, 0);
      if (!busy && prev_busy) observe(K_IDLE, 0);
    end
    prev_rst  = rst;
    prev_n    = rst_req_n;
    prev_busy = busy;
    prev_to   = timeout_err;
  end

  int r0, c0, d0, w0, k0, m0;
  ev_t left;

  initial begin
    // Power-on pulse and release
    tick(3);
    chk("reset_rst_req_n", 32'(rst_req_n), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    chk("reset_cause", 32'(cause), 32'd0);
    rst = 1'b0;
    r0 = cyc;
    push_ev(K_PSTART, r0, 0);
    push_ev(K_PEND, r0 + 16, 16);
    tick_to(r0 + 20);
    ready_in = 1'b1;
    push_ev(K_DONE, r0 + 22, 0);
    push_ev(K_IDLE, r0 + 87, 0);
    tick_to(r0 + 90);

    // Stale ready: ready_in stays high, so the cycle must time out
    c0 = cyc;
    req = 1'b1;
    push_ev(K_PSTART, c0 + 1, 1);
    push_ev(K_PEND, c0 + 17, 16);
    push_ev(K_TOUT, c0 + 1041, 0);
    push_ev(K_IDLE, c0 + 1105, 0);
    tick(1);
    req = 1'b0;
    tick_to(c0 + 1110);
    chk("stale_timeout_sticky", 32'(timeout_err), 32'd1);

    // Simultaneous req+cfg; also clears timeout_err on first ASSERT cycle
    d0 = cyc;
    req = 1'b1;
    cfg_change = 1'b1;
    ready_in = 1'b0;
    push_ev(K_PSTART, d0 + 1, 3);
    push_ev(K_PEND, d0 + 17, 16);
    tick(1);
    req = 1'b0;
    cfg_change = 1'b0;
    tick_to(d0 + 20);
    ready_in = 1'b1;
    push_ev(K_DONE, d0 + 22, 0);
    push_ev(K_IDLE, d0 + 87, 0);

    // cfg_change during HOLDOFF is served right after IDLE entry
    tick_to(d0 + 40);
    cfg_change = 1'b1;
    push_ev(K_PSTART, d0 + 88, 2);
    push_ev(K_PEND, d0 + 104, 16);
    tick(1);
    cfg_change = 1'b0;
    tick_to(d0 + 80);
    ready_in = 1'b0;
    tick_to(d0 + 110);
    ready_in = 1'b1;
    push_ev(K_DONE, d0 + 112, 0);
    push_ev(K_IDLE, d0 + 177, 0);
    tick_to(d0 + 180);
    chk("idle_after_holdoff_req", 32'(busy), 32'd0);

    // Watchdog fires with no kicks
    w0 = cyc;
    wdt_en = 1'b1;
    ready_in = 1'b0;
    push_ev(K_PSTART, w0 + 4097, 4);
    push_ev(K_PEND, w0 + 4113, 16);
    tick_to(w0 + 4120);
    ready_in = 1'b1;
    push_ev(K_DONE, w0 + 4122, 0);
    push_ev(K_IDLE, w0 + 4187, 0);
    tick_to(w0 + 4187);

    // Regular kicks keep it quiet; then a kick exactly on the terminal count
    for (int i = 0; i < 5; i++) begin
      tick(3999);
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
    end
    tick(4095);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    wdt_en = 1'b0;
    tick(10);
    chk("wdt_quiet_busy", 32'(busy), 32'd0);
    chk("wdt_quiet_cause", 32'(cause), 32'd4);

    // Reset in the middle of a pulse restarts a power-on pulse
    m0 = cyc;
    ready_in = 1'b0;
    req = 1'b1;
    push_ev(K_PSTART, m0 + 1, 1);
    tick(1);
    req = 1'b0;
    tick_to(m0 + 8);
    rst = 1'b1;
    tick(1);
    chk("midrst_rst_req_n", 32'(rst_req_n), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    chk("midrst_cause", 32'(cause), 32'd0);
    tick(1);
    rst = 1'b0;
    push_ev(K_PSTART, m0 + 10, 0);
    push_ev(K_PEND, m0 + 26, 16);
    tick_to(m0 + 30);
    ready_in = 1'b1;
    push_ev(K_DONE, m0 + 32, 0);
    push_ev(K_IDLE, m0 + 97, 0);
    tick_to(m0 + 100);

    while (exp_q.size() > 0) begin
      left = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_%s: got no event, required cyc=%0d data=%0h",
               kname(left.kind), left.cyc, left.data);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_requester.md
Name: reset_requester

Overview:
- Initiator side of the reset path. Collects reset requests from a user request, a configuration change and a watchdog, then drives a fixed-width active-low reset pulse into the downstream reset synchroniser.
- Waits for the downstream reset-released indication, reports completion or timeout, then enforces a hold-off before serving the next request.
- Sits between the control/OSD logic and the memory-test core reset input.

Parameters:
- PULSE_LEN, 16: cycles rst_req_n is held low per request (>=2).
- READY_TIMEOUT, 1024: max cycles in WAIT_READY before declaring timeout.
- HOLDOFF, 64: cycles after completion or timeout during which no new pulse starts.
- WDT_LEN, 1048576: idle cycles without wdt_kick before the watchdog requests a reset.
- CNT_W, 21: width of the shared cycle counter; must hold max(PULSE_LEN, READY_TIMEOUT, HOLDOFF, WDT_LEN).

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- req, input, 1: software/user reset request, level, sampled each cycle.
- cfg_change, input, 1: one-cycle pulse on configuration change.
- wdt_en, input, 1: enables the watchdog.
- wdt_kick, input, 1: watchdog service pulse.
- ready_in, input, 1: downstream reset released (high = out of reset). Asynchronous; synchronised internally with 2 flops.
- rst_req_n, output, 1: active-low reset request to the downstream block.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when downstream release is confirmed.
- timeout_err, output, 1: sticky high after a WAIT_READY timeout; cleared when the next ASSERT starts.
- cause, output, 3: {wdt, cfg, req} request bits that started the current or last cycle.

Behaviour:
- All state updates on posedge clk. rst has priority over everything.
- Reset values: state = ASSERT, counter = 0, pending = 0, rst_req_n = 0, busy = 1, done = 0, timeout_err = 0, cause = 000, ready sync flops = 0, seen_low = 0.
- A power-on pulse is issued after rst deasserts.
- Request capture:
  - Every cycle, pending |= {wdt_fire, cfg_change, req}, in all states.
  - Requests arriving while busy are never dropped.
- IDLE (rst_req_n = 1):
  - If pending != 0: cause <= pending, pending <= 0, counter <= 0, timeout_err <= 0, go to ASSERT next cycle.
  - A request seen in cycle N drives rst_req_n low in cycle N+1.
  - A request arriving in the same cycle the transfer occurs is included in cause.
- ASSERT (rst_req_n = 0):
  - Lasts exactly PULSE_LEN cycles, counter 0..PULSE_LEN-1.
  - seen_low <= seen_low | !ready_sync.
  - seen_low is cleared on entry.
  - On counter = PULSE_LEN-1: counter <= 0, go to WAIT_READY.
- WAIT_READY (rst_req_n = 1):
  - seen_low keeps updating.
  - Success when seen_low && ready_sync. This rejects a stale high ready that never dropped.
  - On success: done = 1 for exactly that cycle, counter <= 0, go to HOLDOFF.
  - Timeout when counter = READY_TIMEOUT-1 without success: timeout_err <= 1, done stays 0, counter <= 0, go to HOLDOFF.
  - If success and timeout fall on the same cycle, success wins.
- HOLDOFF (rst_req_n = 1):
  - Lasts HOLDOFF cycles, then go to IDLE.
  - Pending requests are served from IDLE on the following cycle.
  - Minimum spacing between pulse starts is PULSE_LEN + 1 + HOLDOFF + 1 + wait cycles.
- Watchdog:
  - Separate counter, runs only when wdt_en && state = IDLE && pending = 0.
  - Cleared when wdt_kick = 1, when wdt_en = 0, or when not IDLE.
  - wdt_fire = 1 for one cycle when the count reaches WDT_LEN-1 without a kick; the counter then clears.
  - A kick on the same cycle as the terminal count suppresses the fire.
- Counters saturate-free; all compares are exact equality at CNT_W width, unsigned.
- rst asserted mid-operation: immediate return to reset values, so a fresh power-on pulse follows. pending and timeout_err are lost.

Test Plan:
- Power-on: hold rst 3 cycles, ready_in = 0 → rst_req_n low exactly 16 cycles after rst falls, cause = 000. Then raise ready_in → done one-cycle pulse 2 cycles after ready_in rises (sync latency), busy falls 64+1 cycles later.
- Stale ready: ready_in held 1 throughout, req pulse → 16-cycle low pulse, no done. timeout_err = 1 after 1024 WAIT_READY cycles, then HOLDOFF 64, IDLE. Next req clears timeout_err on the first ASSERT cycle.
- Simultaneous requests: req and cfg_change both high in the same IDLE cycle → one pulse, cause = 011.
- Request during HOLDOFF: cfg_change pulsed during HOLDOFF → captured. A second pulse starts one cycle after IDLE entry with cause = 010.
- Watchdog (sim WDT_LEN = 4096): wdt_en = 1 with no kicks → pulse starts 4097 cycles after IDLE entry, cause = 100. Kick every 4000 cycles → no pulse over 20000 cycles. Kick on the terminal-count cycle → no fire.
- Mid-pulse reset: assert rst at ASSERT cycle 7 → outputs return to reset values. After rst drops, a full 16-cycle pulse restarts with cause = 000.
